sprite_update_scheduler: RTL and testbench

- Sits between the Avalon slave (chipselect/write/address/writedata) and Sprite_Controller.
- Buffers CPU sprite-register writes in a FIFO and commits them to an 8-entry shadow register file only during vertical blanking.
- Sprite_Controller therefore never sees a mid-frame update, which prevents tearing.
- Drives the sprite register bus and a per-frame commit strobe.

---
 rtl/sprite_update_scheduler.sv | 99 +++++++++
 tb/tb_sprite_update_scheduler.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/sprite_update_scheduler.sv
// sprite_update_scheduler: queues CPU sprite-register writes and commits them only during vertical blanking.
// Optional SCHED_FRAME_CNT_EN adds a frame_cnt output counting IDLE->DRAIN transitions.
module sprite_update_scheduler #(
    parameter int FIFO_DEPTH   = 16,
    parameter int NUM_REGS     = 8,
    parameter int VBLANK_START = 480,
    parameter int V_TOTAL      = 525
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          chipselect,
    input  logic                          write,
    input  logic [$clog2(NUM_REGS)-1:0]   address,
    input  logic [31:0]                   writedata,
    input  logic [9:0]                    VGA_VCOUNT,
    input  logic                          clr_ovf,
    output logic [32*NUM_REGS-1:0]        sprite_regs,
    output logic                          commit,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic                          ovf,
    output logic                          late
`ifdef SCHED_FRAME_CNT_EN
    ,
    output logic [15:0]                   frame_cnt
`endif
);
    localparam int AW = $clog2(NUM_REGS);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] DRAIN = 2'd1;
    localparam logic [1:0] DONE  = 2'd2;

    logic [AW+31:0] mem [FIFO_DEPTH];
    logic [PW:0]    wptr, rptr;
    logic [1:0]     state, next;
    logic           vblank, vblank_d, empty, full, accept, pop, push;
    logic           pop_valid;
    logic [AW-1:0]  pop_addr;
    logic [31:0]    pop_data;

    assign vblank     = (VGA_VCOUNT >= 10'(VBLANK_START)) && (VGA_VCOUNT < 10'(V_TOTAL));
    assign empty      = wptr == rptr;
    assign full       = (wptr[PW] != rptr[PW]) && (wptr[PW-1:0] == rptr[PW-1:0]);
    assign accept     = chipselect && write;
    assign pop        = (state == DRAIN) && vblank && !empty;
    assign push       = accept && (!full || pop);
    assign fifo_level = wptr - rptr;

    always_comb begin
        next = state == IDLE  ? ((vblank && !vblank_d) ? DRAIN : IDLE)
             : state == DRAIN ? (!vblank ? IDLE : (empty ? DONE : DRAIN))
             : state == DONE  ? (vblank ? DONE : IDLE)
             : IDLE;
    end

    always_ff @(posedge clk) begin
        if (push)
            mem[wptr[PW-1:0]] <= {address, writedata};
    end

    // Popped entries land one edge later so commit coincides with the final register update.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wptr        <= '0;
            rptr        <= '0;
            state       <= IDLE;
            vblank_d    <= 1'b0;
            pop_valid   <= 1'b0;
            pop_addr    <= '0;
            pop_data    <= '0;
            sprite_regs <= '0;
            commit      <= 1'b0;
            ovf         <= 1'b0;
            late        <= 1'b0;
        end else begin
            vblank_d  <= vblank;
            state     <= next;
            wptr      <= wptr + (PW+1)'(push);
            rptr      <= rptr + (PW+1)'(pop);
            pop_valid <= pop;
            {pop_addr, pop_data} <= mem[rptr[PW-1:0]];
            for (int i = 0; i < NUM_REGS; i++)
                if (pop_valid && pop_addr == AW'(i))
                    sprite_regs[32*i +: 32] <= pop_data;
            commit <= (state == DRAIN) && vblank && empty;
            ovf    <= (accept && full && !pop) || (ovf && !clr_ovf);
            late   <= ((state == DRAIN) && !vblank && !empty) || (late && !clr_ovf);
        end
    end

`ifdef SCHED_FRAME_CNT_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            frame_cnt <= '0;
        else if (state == IDLE && next == DRAIN)
            frame_cnt <= frame_cnt + 16'd1;
    end
`endif
endmodule

// File: tb/tb_sprite_update_scheduler.sv
// tb_sprite_update_scheduler: random and directed stimulus checked against a queue-based frame model.
module tb_sprite_update_scheduler;
    localparam int M_IDLE = 0, M_DRAIN = 1, M_DONE = 2;

    logic         clk = 0, reset = 1, cs = 0, wr = 0, clr = 0;
    logic [2:0]   adr = 0;
    logic [31:0]  wd = 0;
    logic [9:0]   vc = 0;
    logic [255:0] sprite_regs;
    logic         commit, ovf, late;
    logic [4:0]   fifo_level;
`ifdef SCHED_FRAME_CNT_EN
    logic [15:0]  frame_cnt;
`endif

    int checks = 0, errors = 0, ncommit = 0;

    logic [34:0]  q[$];
    logic [31:0]  m_regs[8];
    logic         m_pv = 0, m_commit = 0, m_ovf = 0, m_late = 0, m_vbd = 0;
    logic [2:0]   m_pa = 0;
    logic [31:0]  m_pd = 0;
    int           m_mode = M_IDLE;

    sprite_update_scheduler dut (
        .clk(clk), .reset(reset), .chipselect(cs), .write(wr), .address(adr),
        .writedata(wd), .VGA_VCOUNT(vc), .clr_ovf(clr), .sprite_regs(sprite_regs),
        .commit(commit), .fifo_level(fifo_level), .ovf(ovf), .late(late)
`ifdef SCHED_FRAME_CNT_EN
        , .frame_cnt(frame_cnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Frame-level reference: a queue of pending writes and a drain phase per blanking period.
    initial begin
        foreach (m_regs[i]) m_regs[i] = 0;
        forever begin
            @(posedge clk or posedge reset);
            if (reset) begin
                q.delete();
                foreach (m_regs[i]) m_regs[i] = 0;
                m_pv = 0; m_commit = 0; m_ovf = 0; m_late = 0; m_vbd = 0; m_mode = M_IDLE;
            end else begin
                automatic bit vb = vc >= 480;
                automatic int n = q.size();
                automatic bit pop = m_mode == M_DRAIN && vb && n > 0;
                automatic bit acc = cs && wr;
                if (m_pv) m_regs[m_pa] = m_pd;
                m_pv = pop;
                if (pop) {m_pa, m_pd} = q.pop_front();
                if (acc && (n < 16 || pop)) q.push_back({adr, wd});
                m_commit = m_mode == M_DRAIN && vb && n == 0;
                m_ovf = (acc && n == 16 && !pop) || (m_ovf && !clr);
                m_late = (m_mode == M_DRAIN && !vb && n > 0) || (m_late && !clr);
                if (m_mode == M_IDLE) m_mode = (vb && !m_vbd) ? M_DRAIN : M_IDLE;
                else if (m_mode == M_DRAIN) m_mode = !vb ? M_IDLE : (n == 0 ? M_DONE : M_DRAIN);
                else m_mode = vb ? M_DONE : M_IDLE;
                m_vbd = vb;
            end
        end
    end

    always @(negedge clk) begin
        automatic logic [255:0] exp_regs;
        for (int i = 0; i < 8; i++) exp_regs[32*i +: 32] = m_regs[i];
        chk("regs", sprite_regs, exp_regs);
        chk("commit", 256'(commit), 256'(m_commit));
        chk("level", 256'(fifo_level), 256'(q.size()));
        chk("ovf", 256'(ovf), 256'(m_ovf));
        chk("late", 256'(late), 256'(m_late));
        if (commit) ncommit++;
    end

    task automatic cycle();
        @(posedge clk);
        #2;
    endtask

    task automatic idle(input int n);
        repeat (n) cycle();
    endtask

    task automatic put(input logic [2:0] a, input logic [31:0] d);
        cs = 1; wr = 1; adr = a; wd = d;
        cycle();
        cs = 0; wr = 0;
    endtask

    initial begin
        automatic logic [31:0] d[17];
        automatic int c0;
        idle(3);
        chk("rst_regs", sprite_regs, 0);
        chk("rst_level", 256'(fifo_level), 0);
        chk("rst_flags", 256'({commit, ovf, late}), 0);
        reset = 0;
        vc = 100;
        idle(2);

        put(3'd2, 32'hDEADBEEF);
        chk("one_level", 256'(fifo_level), 1);
        chk("one_regs", sprite_regs, 0);
        c0 = ncommit;
        vc = 480;
        idle(6);
        chk("one_reg2", 256'(sprite_regs[95:64]), 256'(32'hDEADBEEF));
        chk("one_commit", 256'(ncommit - c0), 1);
        chk("one_empty", 256'(fifo_level), 0);

        vc = 100; idle(2);
        put(0, 1); put(0, 2); put(0, 3);
        c0 = ncommit;
        vc = 480; idle(8);
        chk("last_wins", 256'(sprite_regs[31:0]), 3);
        chk("three_commit", 256'(ncommit - c0), 1);

        vc = 100; idle(2);
        for (int i = 0; i < 17; i++) begin
            d[i] = $urandom;
            put(3'(i % 8), d[i]);
        end
        chk("ovf_set", 256'(ovf), 1);
        chk("ovf_level", 256'(fifo_level), 16);
        vc = 480; idle(22);
        for (int k = 0; k < 8; k++) chk("ovf_reg", 256'(sprite_regs[32*k +: 32]), 256'(d[8+k]));
        clr = 1; cycle(); clr = 0;
        chk("ovf_clr", 256'(ovf), 0);

        vc = 0; idle(2);
        for (int i = 0; i < 16; i++) put(3'(i % 8), $urandom);
        c0 = ncommit;
        vc = 480; idle(6);
        vc = 0; cycle();
        chk("late_set", 256'(late), 1);
        chk("late_level", 256'(fifo_level), 11);
        chk("late_nocommit", 256'(ncommit - c0), 0);
        idle(2);
        vc = 480; idle(16);
        chk("late_drained", 256'(fifo_level), 0);
        chk("late_commit", 256'(ncommit - c0), 1);
        clr = 1; cycle(); clr = 0;
        chk("late_clr", 256'(late), 0);

        for (int t = 0; t < 3000; t++) begin
            vc = 10'((int'(vc) + $urandom_range(0, 40)) % 525);
            cs = $urandom_range(0, 1); wr = $urandom_range(0, 3) != 0;
            adr = 3'($urandom); wd = $urandom;
            clr = $urandom_range(0, 19) == 0;
            cycle();
        end
        cs = 0; wr = 0; clr = 0;

        reset = 1; idle(2);
        reset = 0;
        for (int f = 0; f < 3; f++) begin
            vc = 0; idle(3);
            vc = 480; idle(3);
        end
`ifdef SCHED_FRAME_CNT_EN
        chk("frame_cnt3", 256'(frame_cnt), 3);
`endif
        vc = 0; idle(2);
        for (int i = 0; i < 6; i++) put(3'(i), 32'h100 + i);
        vc = 480; idle(4);
        #1 reset = 1;
        #1;
        chk("arst_regs", sprite_regs, 0);
        chk("arst_level", 256'(fifo_level), 0);
        chk("arst_commit", 256'(commit), 0);
`ifdef SCHED_FRAME_CNT_EN
        chk("arst_frame", 256'(frame_cnt), 0);
`endif
        idle(2);
        reset = 0;
        idle(3);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
